// File: rtl/mux_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module      : mux_rr_arbiter
// Description : Arbiter that shares one 2:1 mux datapath between two
//               valid/ready requesters (T and F). The winner's payload is
//               registered into a single output stage with a valid/ready
//               handshake; cond records which requester supplied y.
//               Optional macro MUX_RR_ARBITER_FIXED_PRIO_EN replaces the
//               round-robin pointer with fixed priority (T always wins).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             t_valid,
  input  logic [WIDTH-1:0] t_data,
  output logic             t_ready,
  input  logic             f_valid,
  input  logic [WIDTH-1:0] f_data,
  output logic             f_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y,
  input  logic             y_ready,
  output logic             cond
);

  logic             r_y_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_cond;
  logic             w_load_en;
  logic             w_grant_t;
  logic             w_grant_f;

  // The output stage can take a new word when empty or being drained.
  assign w_load_en = !r_y_valid | y_ready;

`ifdef MUX_RR_ARBITER_FIXED_PRIO_EN
  // Fixed priority: T wins every contention.
  always_comb begin
    w_grant_t = t_valid;
    w_grant_f = f_valid & !t_valid;
  end
`else
  // Set when the most recent transfer came from T; cleared means F.
  logic r_last_t;

  // Round-robin: a lone requester wins, contention goes to the one not served last.
  always_comb begin
    w_grant_t = t_valid & (!f_valid | !r_last_t);
    w_grant_f = f_valid & (!t_valid |  r_last_t);
  end

  // Track the last served requester; moves only on an actual transfer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last_t <= 1'b0;
    end else if (t_ready) begin
      r_last_t <= 1'b1;
    end else if (f_ready) begin
      r_last_t <= 1'b0;
    end
  end
`endif

  // Readies are forced low while reset is held so nothing is accepted.
  assign t_ready = reset & w_load_en & w_grant_t;
  assign f_ready = reset & w_load_en & w_grant_f;

  // Output stage: load the granted word, or empty out when drained with no grant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_y_valid <= 1'b0;
      r_y       <= '0;
      r_cond    <= 1'b0;
    end else if (w_load_en) begin
      if (w_grant_t) begin
        r_y       <= t_data;
        r_cond    <= 1'b1;
        r_y_valid <= 1'b1;
      end else if (w_grant_f) begin
        r_y       <= f_data;
        r_cond    <= 1'b0;
        r_y_valid <= 1'b1;
      end else begin
        r_y_valid <= 1'b0;
      end
    end
  end

  assign y_valid = r_y_valid;
  assign y       = r_y;
  assign cond    = r_cond;

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_mux_rr_arbiter
// Description : Self-checking bench for mux_rr_arbiter: reset checks, a table
//               of directed vectors, an async-reset sequence and a random run
//               compared against a priority-list reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux_rr_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       t_valid = 1'b0;
  logic [7:0] t_data = '0;
  logic       t_ready;
  logic       f_valid = 1'b0;
  logic [7:0] f_data = '0;
  logic       f_ready;
  logic       y_valid;
  logic [7:0] y;
  logic       y_ready = 1'b0;
  logic       cond;

  mux_rr_arbiter #(.WIDTH(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .t_valid (t_valid),
    .t_data  (t_data),
    .t_ready (t_ready),
    .f_valid (f_valid),
    .f_data  (f_data),
    .f_ready (f_ready),
    .y_valid (y_valid),
    .y       (y),
    .y_ready (y_ready),
    .cond    (cond)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: 0 = T, 1 = F. prio[0] is the requester served first on contention.
  int         prio [2];
  logic       m_full;
  logic [7:0] m_y;
  logic       m_cond;
  int         m_winner;
  logic       s_tr, s_fr;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full = 1'b0; m_y = '0; m_cond = 1'b0;
    prio[0] = 0; prio[1] = 1;
  endtask

  // Drive inputs at the falling edge, then compare DUT against the model.
  task automatic drive_and_check(input logic tv, input logic [7:0] td,
                                 input logic fv, input logic [7:0] fd,
                                 input logic yr);
    logic vld [2];
    @(negedge clock);
    t_valid = tv; t_data = td; f_valid = fv; f_data = fd; y_ready = yr;
    #1;
    vld[0] = tv; vld[1] = fv;
    m_winner = -1;
    if (reset && (!m_full || yr)) begin
      for (int k = 0; k < 2; k++)
        if (m_winner < 0 && vld[prio[k]]) m_winner = prio[k];
    end
    s_tr = t_ready; s_fr = f_ready;
    chk("t_ready", t_ready, m_winner == 0);
    chk("f_ready", f_ready, m_winner == 1);
    chk("y_valid", y_valid, m_full);
    chk("y",       y,       m_y);
    chk("cond",    cond,    m_cond);
  endtask

  // Clock edge: apply the transfer decided above to the model.
  task automatic advance();
    @(posedge clock);
    if (!reset) begin
      model_reset();
    end else if (m_winner >= 0) begin
      m_y    = (m_winner == 0) ? t_data : f_data;
      m_cond = (m_winner == 0);
      m_full = 1'b1;
`ifndef MUX_RR_ARBITER_FIXED_PRIO_EN
      prio[0] = 1 - m_winner;
      prio[1] = m_winner;
`endif
    end else if (y_ready) begin
      m_full = 1'b0;
    end
  endtask

  typedef struct {
    logic       tv; logic [7:0] td;
    logic       fv; logic [7:0] fd;
    logic       yr;
    logic       etr; logic efr; logic eyv; logic [7:0] ey; logic ec;
  } vec_t;

  vec_t tbl [18];

  initial begin
    logic       tv, fv, yr;
    logic [7:0] td, fd;

    //             tv  td     fv  fd     yr | tr   fr   yv   y      c
    tbl[0]  = '{1'b1, 8'hAA, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 8'hAA, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 8'hAA, 1'b1};
    tbl[2]  = '{1'b1, 8'hAA, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0};
    tbl[3]  = '{1'b1, 8'hAA, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 8'hAA, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0};
    tbl[6]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0};
    for (int i = 7; i < 12; i++)
      tbl[i] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1};
    tbl[12] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1};
    tbl[13] = '{1'b1, 8'h7E, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h7E, 1'b1};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h7E, 1'b1};
    tbl[16] = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 8'h7E, 1'b1};
    tbl[17] = '{1'b1, 8'h01, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0};

    model_reset();

    // Reset held low with both requesters asserting.
    for (int i = 0; i < 16; i++) begin
      drive_and_check(1'b1, 8'hAA, 1'b1, 8'h55, 1'b1);
      advance();
    end
    #1 reset = 1'b1;

`ifndef MUX_RR_ARBITER_FIXED_PRIO_EN
    // Directed vectors: alternation, F-only, back-pressure, drain, last=T contention.
    for (int i = 0; i < 18; i++) begin
      drive_and_check(tbl[i].tv, tbl[i].td, tbl[i].fv, tbl[i].fd, tbl[i].yr);
      chk($sformatf("tbl%0d.t_ready", i), t_ready, tbl[i].etr);
      chk($sformatf("tbl%0d.f_ready", i), f_ready, tbl[i].efr);
      chk($sformatf("tbl%0d.y_valid", i), y_valid, tbl[i].eyv);
      chk($sformatf("tbl%0d.y", i),       y,       tbl[i].ey);
      chk($sformatf("tbl%0d.cond", i),    cond,    tbl[i].ec);
      advance();
    end
`else
    // Fixed priority: T wins every contention, F never served.
    for (int i = 0; i < 6; i++) begin
      drive_and_check(1'b1, 8'hAA, 1'b1, 8'h55, 1'b1);
      chk("fixed.f_ready", f_ready, 0);
      if (i > 0) begin
        chk("fixed.y", y, 8'hAA);
        chk("fixed.cond", cond, 1);
      end
      advance();
    end
`endif

    // Asynchronous reset pulse while the output stage is full.
    drive_and_check(1'b1, 8'h5A, 1'b1, 8'hA5, 1'b1);
    advance();
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("async.y_valid", y_valid, 0);
    chk("async.y",       y,       0);
    chk("async.cond",    cond,    0);
    chk("async.t_ready", t_ready, 0);
    chk("async.f_ready", f_ready, 0);
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive_and_check(1'b1, 8'h5A, 1'b1, 8'hA5, 1'b1);
      advance();
    end
    #1 reset = 1'b1;
    drive_and_check(1'b1, 8'h5A, 1'b1, 8'hA5, 1'b1);
    chk("post_reset.t_wins", t_ready, 1);
    advance();

    // Random traffic honouring the hold-until-ready contract.
    tv = 1'b0; fv = 1'b0; td = '0; fd = '0;
    for (int i = 0; i < 600; i++) begin
      if (!(tv && !s_tr)) begin
        tv = ($urandom_range(0, 2) != 0);
        td = 8'($urandom);
      end
      if (!(fv && !s_fr)) begin
        fv = ($urandom_range(0, 2) != 0);
        fd = 8'($urandom);
      end
      yr = ($urandom_range(0, 3) != 0);
      drive_and_check(tv, td, fv, fd, yr);
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one 2:1 mux datapath (cond/t/f -> y) between two valid/ready requesters, T and F.
- Each cycle it picks a winner, drives the mux select and registers the selected payload into a single output stage with a valid/ready handshake.
- Sits in front of any shared mux_*-style primitive; sustains one transfer per cycle under back-pressure-free conditions.

Parameters:
- WIDTH, 8, payload width of t_data, f_data, y.

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- t_valid  input  1  requester T has data.
- t_data  input  WIDTH  requester T payload.
- t_ready  output  1  T transfer accepted this cycle.
- f_valid  input  1  requester F has data.
- f_data  input  WIDTH  requester F payload.
- f_ready  output  1  F transfer accepted this cycle.
- y_valid  output  1  output stage holds data.
- y  output  WIDTH  registered mux output.
- y_ready  input  1  consumer accepts y.
- cond  output  1  registered select of the word in y: 1 = from T, 0 = from F.

Behaviour:
- Reset (reset low, async): y_valid=0, y=0, cond=0, last=F (so T wins first contention); t_ready=f_ready=0 while reset is low.
- Output stage states: EMPTY (y_valid=0), FULL (y_valid=1). load_en = !y_valid | y_ready.
- Arbitration (combinational, only when load_en=1):
  - Only T valid -> grant T.
  - Only F valid -> grant F.
  - Both valid -> grant the requester not equal to last.
  - Neither valid -> no grant.
- t_ready = load_en & grant_T; f_ready = load_en & grant_F. At most one is high per cycle. Ready does not depend on the requester's own valid beyond arbitration.
- On a grant: y <= granted data, cond <= (grant==T), y_valid <= 1, last <= granted requester. Latency is 1 cycle from accepted request to y_valid.
- FULL with y_ready=1 and no grant: y_valid <= 0. y and cond hold their last values.
- FULL with y_ready=1 and a grant: the new word is loaded in the same cycle. y_valid stays 1, giving full throughput.
- FULL with y_ready=0: y, cond and y_valid hold. Both readies are 0, and last does not change.
- Requesters must hold valid/data stable until ready. The arbiter does not latch pending requests, and dropping valid early is allowed (no grant results).
- last changes only on an actual transfer, never on idle cycles.
- Reset asserted mid-transfer discards the output word immediately (y_valid=0 asynchronously). An accepted input in that cycle is lost, as the upstream contract permits.

Optional Feature:
- Macro MUX_RR_ARBITER_FIXED_PRIO_EN.
- Defined: fixed priority. T always wins contention, and last is neither implemented nor updated.
- Undefined: round-robin as above. All other behaviour is identical.

Test Plan:
- Reset held low 16 cycles with t_valid=f_valid=1 -> t_ready=f_ready=0, y_valid=0, y=0, cond=0. After release, first grant goes to T: y=t_data, cond=1.
- Both valid continuously, t_data=8'hAA, f_data=8'h55, y_ready=1 -> y sequence AA,55,AA,55 on consecutive cycles; cond sequence 1,0,1,0; y_valid constantly 1. With FIXED_PRIO_EN: y=AA every cycle, cond=1, f_ready never high.
- Only F valid, f_data=8'h3C, y_ready=1 -> f_ready=1 every cycle, y=3C and cond=0 one cycle later, t_ready=0.
- Back-pressure: load T=8'h11 with y_ready=0 for 5 cycles, both requesters valid -> y=11 and cond=1 held, t_ready=f_ready=0. Raise y_ready -> next y=F's data (last=T), cond=0.
- Drain: single T word 8'h7E, then t_valid=0 -> y_valid high one cycle, then 0 with y=7E retained. A later contention grants F first, since last=T.
- Async reset pulse mid-stream while y_valid=1 -> y_valid drops without a clock edge. After release, arbitration restarts with T winning contention.
